// File: rtl/coproc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coproc_pkg
// Purpose  : Shared definitions for the matrix coprocessor: default matrix
//            dimension and element width, opcode codes, controller state
//            encoding and a helper for sizing the element counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package coproc_pkg;

  localparam int unsigned MAT_N  = 5;
  localparam int unsigned ELEM_W = 8;

  typedef enum logic [1:0] {
    OP_TRANSPOSE = 2'b00,
    OP_COPY      = 2'b01,
    OP_NEGATE    = 2'b10,
    OP_RESERVED  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Counter width for addressing 'elems' elements; a single element still
  // needs one bit so the counter never collapses to zero width.
  function automatic int unsigned cnt_width(input int unsigned elems);
    return (elems > 1) ? $clog2(elems) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/transposicao_matriz.sv
`default_nettype none
// ============================================================================
// Module   : transposicao_matriz
// Purpose  : Purely combinational N x N matrix transpose. Elements are packed
//            row-major, element (i,j) at bits [(i*N+j)*W +: W].
// Ports    : mat_in  - packed source matrix A
//            mat_out - packed result R, R[i][j] = A[j][i]
// Revision : 1.0 - initial release
// ============================================================================
module transposicao_matriz
  import coproc_pkg::*;
#(
  parameter int unsigned N = MAT_N,
  parameter int unsigned W = ELEM_W
) (
  input  logic [N*N*W-1:0] mat_in,
  output logic [N*N*W-1:0] mat_out
);

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign mat_out[(i*N+j)*W +: W] = mat_in[(j*N+i)*W +: W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/controle_matriz.sv
`default_nettype none
// ============================================================================
// Module   : controle_matriz
// Purpose  : Matrix coprocessor controller. Streams an N x N signed matrix in
//            row-major order, applies transpose / copy / negate in a single
//            EXEC cycle, then streams the result out row-major.
// Ports    : clk, rst_n           - clock, async active-low reset
//            start, op            - command strobe and opcode (IDLE only)
//            in_valid/in_ready    - load stream handshake, in_data element
//            out_valid/out_ready  - result stream handshake, out_data element
//            out_last             - out_data is the final element
//            busy, done, error    - not-idle, completion pulse, reserved-op
// Revision : 1.0 - initial release
// ============================================================================
module controle_matriz
  import coproc_pkg::*;
#(
  parameter int unsigned N = MAT_N,
  parameter int unsigned W = ELEM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int unsigned NE = N * N;
  localparam int unsigned MW = NE * W;
  localparam int unsigned KW = cnt_width(NE);
  localparam logic [KW-1:0] K_LAST = KW'(NE - 1);

  state_t        state;
  op_t           op_q;
  logic [KW-1:0] k;
  logic [MW-1:0] mat_q;
  logic [MW-1:0] res_q;

  logic [MW-1:0] transposed;
  logic [MW-1:0] negated;
  logic [MW-1:0] result_next;

  // --------------------------------------------------------------------------
  // Datapath: transpose via the shared block, copy and negate inline
  // --------------------------------------------------------------------------
  transposicao_matriz #(
    .N (N),
    .W (W)
  ) u_transp (
    .mat_in  (mat_q),
    .mat_out (transposed)
  );

  // Unary minus in a W-bit context wraps, so the most negative value maps
  // onto itself.
  for (genvar e = 0; e < NE; e++) begin : g_neg
    assign negated[e*W +: W] = -mat_q[e*W +: W];
  end

  always_comb begin
    result_next = mat_q;
    case (op_q)
      OP_TRANSPOSE: result_next = transposed;
      OP_NEGATE:    result_next = negated;
      default:      result_next = mat_q;
    endcase
  end

  // Result element selected by the shared counter; forced to zero outside
  // UNLOAD so the bus is quiet whenever out_valid is low.
  always_comb begin
    out_data = '0;
    if (state == ST_UNLOAD) begin
      out_data = res_q[32'(k)*W +: W];
    end
  end

  // --------------------------------------------------------------------------
  // Controller: state, counter, operand/result storage and registered flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_TRANSPOSE;
      k         <= '0;
      mat_q     <= '0;
      res_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // done and error are single-cycle pulses
      done  <= 1'b0;
      error <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op_t'(op) == OP_RESERVED) begin
              error <= 1'b1;
            end else begin
              op_q     <= op_t'(op);
              k        <= '0;
              state    <= ST_LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          // in_ready is always high here, so in_valid alone is the beat
          if (in_valid) begin
            mat_q[32'(k)*W +: W] <= in_data;
            if (k == K_LAST) begin
              k        <= '0;
              state    <= ST_EXEC;
              in_ready <= 1'b0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end

        ST_EXEC: begin
          res_q     <= result_next;
          state     <= ST_UNLOAD;
          out_valid <= 1'b1;
          out_last  <= (K_LAST == '0);
        end

        ST_UNLOAD: begin
          // Nothing moves without out_ready, which keeps out_data and
          // out_last stable under backpressure.
          if (out_ready) begin
            if (k == K_LAST) begin
              k         <= '0;
              state     <= ST_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              k        <= k + 1'b1;
              out_last <= ((k + 1'b1) == K_LAST);
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          k         <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_matriz.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_matriz
// Purpose  : Self-checking bench for controle_matriz. Matrices are generated
//            with $urandom (plus fixed patterns) and results are compared
//            against a row/column reference model of the three operations.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_matriz;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NE = N * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         error;

  int vectors     = 0;
  int miscompares = 0;
  int mat_a[NE];

  always #5 clk = ~clk;

  controle_matriz #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: element number idx (row-major) of the result matrix.
  function automatic int model_elem(input int opc, input int idx);
    int r = idx / N;
    int c = idx % N;
    int v;
    case (opc)
      0:       v = mat_a[c*N + r];
      1:       v = mat_a[idx];
      default: begin
        v = -mat_a[idx];
        if (v > 127) v = v - 256;
      end
    endcase
    return v;
  endfunction

  task automatic fill_random();
    for (int e = 0; e < NE; e++) mat_a[e] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic fill_const(input int val);
    for (int e = 0; e < NE; e++) mat_a[e] = val;
  endtask

  // One full command: start, load mat_a, collect and check the result.
  // rmode: 0 = out_ready always high, 1 = toggles every 3 cycles, 2 = random.
  task automatic run_op(input int opc, input int rmode, input bit min_lat,
                        input bit poke_start);
    int idx, oi, cyc, edges, first_valid, held_d, held_l;
    bit acc, stalled;

    op    = 2'(opc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    check("in_ready_in_load", int'(in_ready), 1);
    check("busy_in_load", int'(busy), 1);

    idx = 0;
    cyc = 0;
    while (idx < NE && cyc < 500) begin
      in_valid = in_ready && (min_lat || $urandom_range(0, 3) != 0);
      in_data  = W'(mat_a[idx]);
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      edges++;
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    if (idx < NE) check("load_timeout", idx, NE);
    check("in_ready_after_load", int'(in_ready), 0);
    check("out_valid_in_exec", int'(out_valid), 0);

    oi          = 0;
    cyc         = 0;
    stalled     = 1'b0;
    first_valid = -1;
    held_d      = 0;
    held_l      = 0;
    while (oi < NE && cyc < 1000) begin
      if (out_valid && first_valid < 0) first_valid = edges;
      if (stalled) begin
        check("stall_data", int'($signed(out_data)), held_d);
        check("stall_last", int'(out_last), held_l);
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc / 3) % 2) == 0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke_start && cyc == 2) begin
        start = 1'b1;
        op    = 2'((opc + 1) % 3);
      end else begin
        start = 1'b0;
      end
      stalled = out_valid && !out_ready;
      held_d  = int'($signed(out_data));
      held_l  = int'(out_last);
      if (out_valid && out_ready) begin
        check("data", int'($signed(out_data)), model_elem(opc, oi));
        check("last", int'(out_last), int'(oi == NE - 1));
        oi++;
      end
      @(posedge clk); #1;
      edges++;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    if (oi < NE) check("unload_timeout", oi, NE);
    if (min_lat) check("first_valid_latency", first_valid, NE + 2);

    check("done_pulse", int'(done), 1);
    check("busy_in_done", int'(busy), 1);
    check("out_valid_in_done", int'(out_valid), 0);
    check("error_quiet", int'(error), 0);
    @(posedge clk); #1;
    check("done_cleared", int'(done), 0);
    check("busy_idle", int'(busy), 0);
    check("in_ready_idle", int'(in_ready), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Transpose of 5i+j at full throughput
    for (int e = 0; e < NE; e++) mat_a[e] = e;
    run_op(0, 0, 1'b1, 1'b0);

    // Negate boundary values
    fill_const(-128);
    run_op(2, 0, 1'b1, 1'b0);
    fill_const(1);
    run_op(2, 0, 1'b1, 1'b0);
    fill_const(127);
    run_op(2, 0, 1'b1, 1'b0);

    // Copy under periodic backpressure
    fill_random();
    run_op(1, 1, 1'b0, 1'b0);

    // Reserved opcode
    op    = 2'b11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rsv_error", int'(error), 1);
    check("rsv_busy", int'(busy), 0);
    check("rsv_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("rsv_error_pulse", int'(error), 0);
    check("rsv_busy_after", int'(busy), 0);
    check("rsv_in_ready_after", int'(in_ready), 0);

    // Reset after 12 load beats, then a fresh transpose
    fill_random();
    op    = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 12; b++) begin
      in_valid = 1'b1;
      in_data  = W'(mat_a[b]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midload_rst_busy", int'(busy), 0);
    check("midload_rst_in_ready", int'(in_ready), 0);
    check("midload_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", int'(busy), 0);
    check("post_rst_no_done", int'(done), 0);
    fill_random();
    run_op(0, 0, 1'b1, 1'b0);

    // start pulsed during UNLOAD must be ignored
    fill_random();
    run_op(2, 2, 1'b0, 1'b1);
    fill_random();
    run_op(0, 1, 1'b0, 1'b1);

    // Random mix
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_op(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0,
             1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controle_matriz.md
CONTROLE_MATRIZ -- requirements
Module: controle_matriz

Interface
REQ-001 SHALL have parameter N, default 5, meaning matrix dimension (N x N).
REQ-002 SHALL have parameter W, default 8, meaning signed element width in bits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning command strobe; sampled only in IDLE.
REQ-006 SHALL have port op, input, 2, meaning opcode: 00 transpose, 01 copy, 10 negate, 11 reserved.
REQ-007 SHALL have port in_valid / in_ready, input / output, 1 each, meaning load-stream handshake.
REQ-008 SHALL have port in_data, input, W, meaning signed element being loaded.
REQ-009 SHALL have port out_valid / out_ready, output / input, 1 each, meaning result-stream handshake.
REQ-010 SHALL have port out_data, output, W, meaning signed result element.
REQ-011 SHALL have port out_last, output, 1, meaning current out_data is element N*N-1.
REQ-012 SHALL have ports busy, done and error, each an output of width 1, meaning not IDLE, completion pulse and reserved-op pulse.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, EXEC, UNLOAD and DONE.
REQ-014 IDLE: start=1 with op!=11 latches op and moves to LOAD next cycle; start=1 with op=11 pulses error for 1 cycle and stays in IDLE.
REQ-015 LOAD: in_ready=1; each in_valid&in_ready beat writes in_data into element k at bits [k*W +: W], with k=i*N+j row-major, then increments k.
REQ-016 LOAD: the beat with k=N*N-1 clears k and moves to EXEC; in_valid=0 stalls without changing k.
REQ-017 EXEC: lasts exactly 1 cycle and registers the full N*N*W result word.
REQ-018 EXEC result for transpose: R[i][j]=A[j][i].
REQ-019 EXEC result for copy: R=A.
REQ-020 EXEC result for negate: R[i][j]=-A[i][j] in two's complement wrapping to W bits, so -(-128)=-128 for W=8.
REQ-021 UNLOAD: out_valid=1; out_data is result element k; k advances only on out_valid&out_ready.
REQ-022 UNLOAD: out_data and out_last SHALL hold stable while out_ready=0.
REQ-023 UNLOAD: out_last=1 exactly when k=N*N-1; that handshake moves to DONE.
REQ-024 DONE: done=1 for exactly 1 cycle, then IDLE.
REQ-025 start SHALL be ignored in every state other than IDLE.
REQ-026 in_ready SHALL be 0 outside LOAD, and out_valid SHALL be 0 outside UNLOAD.
REQ-027 busy SHALL be 1 in LOAD, EXEC, UNLOAD and DONE, and 0 in IDLE.
REQ-028 Minimum latency SHALL be: start at cycle T, first load beat at T+1, last load beat at T+N*N, EXEC at T+N*N+1, first out_valid at T+N*N+2.
REQ-029 Element counter SHALL be ceil(log2(N*N)) bits wide and SHALL never exceed N*N-1.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, k=0, latched op=00, and clear the matrix and result registers to 0.
REQ-031 On reset, in_ready, out_valid, out_last, out_data, busy, done and error SHALL all be 0.
REQ-032 Reset asserted mid-LOAD or mid-UNLOAD SHALL abandon the operation with no done pulse; the first cycle after release is IDLE.

Structure
REQ-033 N, W, the opcode codes and the state encoding SHALL live in shared package/include coproc_pkg.
REQ-034 The transpose datapath SHALL be the existing combinational transposicao_matriz instantiated once (N=5, W=8); copy and negate SHALL be inline logic.
REQ-035 RTL scope SHALL be the FSM, the counter, a 200-bit operand register, a 200-bit result register and the output element mux.

Verification
REQ-036 Transpose: load A[i][j]=5i+j (0..24), op=00, out_ready=1 -> outputs 0,5,10,15,20,1,6,...,24; out_last only on 24; one done pulse.
REQ-037 Negate: load all 25 elements = -128, then 1, then 127 in separate runs, op=10 -> outputs -128, -1 and -127 respectively, each with error=0.
REQ-038 Backpressure: toggle out_ready every 3 cycles during a copy run -> no element is lost or duplicated, and out_data is stable while stalled.
REQ-039 Reserved op: start with op=11 -> error=1 for 1 cycle, busy stays 0, in_ready stays 0.
REQ-040 Reset mid-LOAD: assert rst_n=0 after 12 beats, then run a new transpose -> the new output matches a fresh 25-beat load exactly.
REQ-041 start pulsed during UNLOAD -> ignored; the current result completes and IDLE follows DONE.
